// File: rtl/trigger_sequencer.sv
// Multi-channel periodic trigger generator: a shared phase counter with period D drives
// per-channel one-cycle pulses at programmable offsets, in continuous, burst or single mode.
module trigger_sequencer #(
   parameter int unsigned CHANNELS    = 4,
   parameter int unsigned DIV_WIDTH   = 32,
   parameter int unsigned COUNT_WIDTH = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [DIV_WIDTH-1:0]          divider,
   input  logic [CHANNELS*DIV_WIDTH-1:0] delays,
   input  logic [1:0]                    mode,
   input  logic [COUNT_WIDTH-1:0]        burst_len,
   input  logic                          start,
   input  logic                          stop,
   output logic [CHANNELS-1:0]           trigger,
   output logic                          busy,
   output logic                          done,
   output logic [COUNT_WIDTH-1:0]        period_count
);

   typedef enum logic {StIdle, StRun} state_e;

   localparam logic [1:0] ModeCont   = 2'd0;
   localparam logic [1:0] ModeBurst  = 2'd1;
   localparam logic [1:0] ModeSingle = 2'd2;
   localparam logic [1:0] ModeRsvd   = 2'd3;

   localparam logic [DIV_WIDTH-1:0]   DivOne = DIV_WIDTH'(1);
   localparam logic [COUNT_WIDTH-1:0] CntOne = COUNT_WIDTH'(1);

   state_e                        state_q, state_d;
   logic [DIV_WIDTH-1:0]          div_q, div_d;
   logic [CHANNELS*DIV_WIDTH-1:0] delays_q, delays_d;
   logic [1:0]                    mode_q, mode_d;
   logic [COUNT_WIDTH-1:0]        n_q, n_d;
   logic [DIV_WIDTH-1:0]          phase_q, phase_d;
   logic [COUNT_WIDTH-1:0]        count_q, count_d;
   logic [CHANNELS-1:0]           trig_q, trig_d;
   logic                          done_q, done_d;
   logic                          accept;
   logic                          last_phase;

   always_comb begin
      state_d  = state_q;
      div_d    = div_q;
      delays_d = delays_q;
      mode_d   = mode_q;
      n_d      = n_q;
      phase_d  = phase_q;
      count_d  = count_q;
      done_d   = 1'b0;
      trig_d   = '0;

      accept = start && !stop && (divider != '0) && (mode != ModeRsvd) &&
               ((mode != ModeBurst) || (burst_len != '0));
      last_phase = (phase_q == div_q - DivOne);

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               state_d  = StRun;
               div_d    = divider;
               delays_d = delays;
               mode_d   = mode;
               n_d      = (mode == ModeSingle) ? CntOne : burst_len;
               phase_d  = '0;
               count_d  = CntOne;
            end
         end
         StRun: begin
            if (stop) begin
               state_d = StIdle;
               phase_d = '0;
            end else if (last_phase) begin
               phase_d = '0;
               // Bounded modes end on the last phase of period N; count stays at N.
               if ((mode_q != ModeCont) && (count_q == n_q)) begin
                  state_d = StIdle;
                  done_d  = 1'b1;
               end else begin
                  count_d = count_q + CntOne;
               end
            end else begin
               phase_d = phase_q + DivOne;
            end
         end
         default: state_d = StIdle;
      endcase

      // Pulses are registered, so decode against the phase of the coming cycle.
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         trig_d[i] = (state_d == StRun) && (delays_d[i*DIV_WIDTH +: DIV_WIDTH] == phase_d);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= StIdle;
         div_q    <= '0;
         delays_q <= '0;
         mode_q   <= '0;
         n_q      <= '0;
         phase_q  <= '0;
         count_q  <= '0;
         trig_q   <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         div_q    <= div_d;
         delays_q <= delays_d;
         mode_q   <= mode_d;
         n_q      <= n_d;
         phase_q  <= phase_d;
         count_q  <= count_d;
         trig_q   <= trig_d;
         done_q   <= done_d;
      end
   end

   assign trigger      = trig_q;
   assign busy         = (state_q == StRun);
   assign done         = done_q;
   assign period_count = count_q;

endmodule

// File: tb/tb_trigger_sequencer.sv
// Directed bench for trigger_sequencer: per-cycle comparison against a small timing model
// of pulse positions, busy window, done pulse and period count.
module tb_trigger_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] divider;
   logic [127:0] delays;
   logic [1:0]  mode;
   logic [15:0] burst_len;
   logic        start;
   logic        stop;
   logic [3:0]  trigger;
   logic        busy;
   logic        done;
   logic [15:0] period_count;

   int n_checks = 0;
   int n_pass   = 0;

   // Model of the run in progress
   int m_d;
   int m_dly[4];
   int m_mode;
   int m_n;

   trigger_sequencer #(
      .CHANNELS   (4),
      .DIV_WIDTH  (32),
      .COUNT_WIDTH(16)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .divider     (divider),
      .delays      (delays),
      .mode        (mode),
      .burst_len   (burst_len),
      .start       (start),
      .stop        (stop),
      .trigger     (trigger),
      .busy        (busy),
      .done        (done),
      .period_count(period_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [3:0] exp_trig(input int k);
      logic [3:0] t;
      bit in_run;
      t = '0;
      in_run = (m_mode == 0) || (k <= m_n * m_d);
      for (int i = 0; i < 4; i++)
         if (in_run && m_dly[i] < m_d && ((k - 1) % m_d) == m_dly[i]) t[i] = 1'b1;
      return t;
   endfunction

   // Drives a start pulse; returns at the sampling point of cycle t+1.
   task automatic do_start(input int d, input int d0, input int d1, input int d2, input int d3,
                           input int md, input int bl);
      m_d = d;
      m_dly[0] = d0; m_dly[1] = d1; m_dly[2] = d2; m_dly[3] = d3;
      m_mode = md;
      m_n = (md == 2) ? 1 : bl;
      divider   = d;
      delays    = {32'(d3), 32'(d2), 32'(d1), 32'(d0)};
      mode      = 2'(md);
      burst_len = 16'(bl);
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic check_cycles(input string name, input int k0, input int k1);
      for (int k = k0; k <= k1; k++) begin
         bit in_run;
         in_run = (m_mode == 0) || (k <= m_n * m_d);
         check($sformatf("%s trig k=%0d", name, k), 32'(trigger), 32'(exp_trig(k)));
         check($sformatf("%s busy k=%0d", name, k), 32'(busy), 32'(in_run));
         check($sformatf("%s done k=%0d", name, k), 32'(done),
               32'((m_mode != 0) && (k == m_n * m_d + 1)));
         check($sformatf("%s count k=%0d", name, k), 32'(period_count),
               in_run ? 32'(1 + (k - 1) / m_d) : 32'(m_n));
         if (k < k1) @(negedge clk);
      end
   endtask

   task automatic check_idle(input string name, input int cnt);
      check({name, " trig"}, 32'(trigger), 32'd0);
      check({name, " busy"}, 32'(busy), 32'd0);
      check({name, " done"}, 32'(done), 32'd0);
      check({name, " count"}, 32'(period_count), 32'(cnt));
   endtask

   task automatic illegal_start(input string name, input int d, input int md, input int bl);
      divider   = d;
      mode      = 2'(md);
      burst_len = 16'(bl);
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_idle({name, " a"}, 2);
      @(negedge clk);
      check_idle({name, " b"}, 2);
   endtask

   initial begin
      reset = 1'b1;
      divider = '0; delays = '0; mode = '0; burst_len = '0; start = 1'b0; stop = 1'b0;
      repeat (2) @(negedge clk);
      check_idle("reset", 0);
      reset = 1'b0;
      @(negedge clk);

      // Continuous, D=10, delays {0,3,9,12}; ch3 never fires
      do_start(10, 0, 3, 9, 12, 0, 0);
      check_cycles("t1", 1, 25);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      check_idle("t1 stop", 3);
      @(negedge clk);

      // Burst of 3 periods
      do_start(10, 0, 3, 9, 12, 1, 3);
      check_cycles("t2", 1, 33);

      // Single shot, D=1, all delays 0; burst_len must be ignored
      do_start(1, 0, 0, 0, 0, 2, 5);
      check_cycles("t3", 1, 4);

      // Stop together with start at t+15
      do_start(10, 0, 3, 9, 12, 0, 0);
      check_cycles("t4", 1, 15);
      start = 1'b1;
      stop  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
      for (int j = 0; j < 3; j++) begin
         check_idle($sformatf("t4 idle%0d", j), 2);
         @(negedge clk);
      end

      // Rejected starts
      illegal_start("t5 div0", 0, 0, 3);
      illegal_start("t5 mode3", 10, 3, 3);
      illegal_start("t5 burst0", 10, 1, 0);

      // Live config changes and a second start during RUN have no effect
      do_start(10, 0, 3, 9, 12, 0, 0);
      check_cycles("t5", 1, 4);
      divider   = 5;
      delays    = {32'd1, 32'd1, 32'd1, 32'd1};
      mode      = 2'd1;
      burst_len = 16'd1;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_cycles("t5b", 5, 25);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      @(negedge clk);

      // Reset mid-burst, then a fresh burst
      do_start(10, 0, 3, 9, 12, 1, 3);
      check_cycles("t6", 1, 7);
      reset = 1'b1;
      #1;
      check_idle("t6 reset", 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_idle("t6 after", 0);
      do_start(4, 1, 0, 3, 5, 1, 2);
      check_cycles("t6b", 1, 10);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/trigger_sequencer.md
Name: trigger_sequencer

Overview:
Multi-channel periodic trigger generator. It is the parametrised successor of the single-output divider trigger used to pace SPI/ADC conversions. A shared phase counter runs at a programmable period, and each channel fires one-cycle pulses at its own phase offset. Supports continuous, burst (N periods) and single-shot modes with start/stop control and completion reporting. Sits between the AXI register bank and the SPI/ADC transaction engines.

Parameters:
CHANNELS, 4, number of trigger outputs (1..16)
DIV_WIDTH, 32, width of period divider and per-channel delays
COUNT_WIDTH, 16, width of burst length and period counter

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
divider  in  DIV_WIDTH  period D in clk cycles; latched on accepted start
delays  in  CHANNELS*DIV_WIDTH  packed phase offsets; channel i at [i*DIV_WIDTH +: DIV_WIDTH]; latched on start
mode  in  2  0 continuous, 1 burst, 2 single, 3 reserved; latched on start
burst_len  in  COUNT_WIDTH  periods N in burst mode; latched on start
start  in  1  level-sampled start request
stop  in  1  level-sampled abort request
trigger  out  CHANNELS  one-cycle trigger pulses, registered
busy  out  1  high while in RUN
done  out  1  one-cycle pulse on natural burst/single completion
period_count  out  COUNT_WIDTH  periods begun since last accepted start

Behaviour:
- Reset (async assert, sync release): state IDLE; trigger=0, busy=0, done=0, period_count=0; latched config cleared.
- States: IDLE, RUN.
- IDLE -> RUN when start=1, stop=0, divider!=0, mode!=3, and (mode!=1 or burst_len!=0). Otherwise start is ignored; no outputs change.
- Accepted start in cycle t: config latched. Effective N = burst_len (mode 1), 1 (mode 2), unbounded (mode 0). From cycle t+1: busy=1, phase p=0, period_count=1.
- Phase p counts 0..D-1 and wraps to 0. On each wrap period_count increments; it wraps modulo 2^COUNT_WIDTH in continuous mode.
- trigger[i] is high exactly in RUN cycles where p == delay_i. Pulses occur at t+1+delay_i+k*D.
- delay_i >= D: channel i never fires. Multiple channels with equal delay fire in the same cycle.
- D=1: p stays 0; every channel with delay 0 fires every cycle.
- Burst/single: RUN lasts exactly N*D cycles (t+1 .. t+N*D). Every channel with delay<D fires exactly N times. At t+N*D+1: IDLE, busy=0, done=1 for one cycle. period_count holds N in IDLE.
- Continuous mode never self-terminates.
- stop=1 in RUN: next cycle IDLE, busy=0, trigger=0, done stays 0, period_count holds. Stop wins over a simultaneous start.
- start while RUN: ignored. Live changes to divider/delays/mode/burst_len during RUN have no effect.
- start in the same cycle as a done pulse (state already IDLE): accepted normally.
- reset mid-run: immediate return to reset values; no done pulse.

Test Plan:
1. CHANNELS=4, D=10, delays {0,3,9,12}, mode 0, start at cycle t -> ch0 pulses at t+1,t+11,t+21; ch1 at t+4,t+14; ch2 at t+10,t+20; ch3 never fires; busy stays 1; period_count=3 at t+21.
2. Mode 1, burst_len=3, D=10, same delays -> ch0/1/2 each fire exactly 3 times; busy high t+1..t+30; done single pulse at t+31; period_count=3 afterwards.
3. Mode 2, D=1, delays all 0 -> every channel pulses once at t+1; done at t+2; period_count=1.
4. Continuous run with D=10; stop asserted at t+15, with start also high -> no trigger from t+16 on; busy=0 at t+16; done never asserted; period_count holds 2.
5. Illegal starts: divider=0, mode=3, or mode 1 with burst_len=0 -> busy, trigger and done stay 0. Change divider to 5 mid-run with D=10 -> period remains 10.
6. Assert reset at t+7 during a burst -> outputs 0 immediately. After release, a fresh start restarts with period_count=1 and correct phases.
